ocx_tlx_axi_wr_tracker: RTL and testbench
=========================================

// Module: ocx_tlx_axi_wr_tracker
// PURPOSE
// Per-ID AXI write tracker between the AXI slave front end and the OpenCAPI command encoder. Collects multi-beat
// write data into per-ID slots and issues one OpenCAPI write command per completed slot. Returns AXI B responses,
// with a per-slot timeout that retires writes the OpenCAPI side never answers. Extends the single-beat write path to
// MAX_BEATS beats, adds length checking and timeout handling, and flow-controls the AXI side.
// PARAMETERS
// ADDR_WIDTH      64    address width
// DATA_WIDTH      64    AXI beat width
// ID_WIDTH        4     AXI ID width; 2**ID_WIDTH slots
// MAX_BEATS       4     data beats buffered per slot (awlen max MAX_BEATS-1)
// TIMEOUT_CYCLES  1024  cycles ISSUED before DECERR retire; 0 disables timeout
// PORTS
// s0_axi_aclk            in   1                      clock
// s0_axi_aresetn         in   1                      asynchronous active-low reset
// axi_trans_awid         in   ID_WIDTH               write address ID
// axi_trans_awaddr       in   ADDR_WIDTH             write address
// axi_trans_awlen        in   8                      beats-1
// axi_trans_awvalid      in   1                      address valid
// axi_trans_awready      out  1                      address accepted
// axi_trans_wid          in   ID_WIDTH               data ID
// axi_trans_wdata        in   DATA_WIDTH             data beat
// axi_trans_wlast        in   1                      final beat
// axi_trans_wvalid       in   1                      data valid
// axi_trans_wready       out  1                      data accepted
// axi_write_response_ready       out  1              B response valid
// axi_write_response_ready_id    out  ID_WIDTH       B ID
// axi_write_response_ready_response out 2            BRESP
// axi_write_response_taken       in   1              B accepted this cycle
// oc_write_command_ready         out  1              command valid
// oc_write_command_ready_id      out  ID_WIDTH       command tag
// oc_write_command_ready_address out  ADDR_WIDTH     command address
// oc_write_command_ready_length  out  8              awlen
// oc_write_command_ready_data    out  MAX_BEATS*DATA_WIDTH  beats, beat0 in LSBs
// oc_write_command_taken         in   1              command accepted this cycle
// oc_trans_bvalid / oc_trans_bid / oc_trans_bresp  in  1/ID_WIDTH/2  OpenCAPI write response
// timeout_err            out  1                      1-cycle pulse, a slot timed out
// stray_resp             out  1                      1-cycle pulse, oc_trans_bvalid hit a non-ISSUED slot
// BEHAVIOUR
// - Reset (async, any cycle incl. mid-burst): all slots IDLE, beat counters/timers 0, all outputs 0; buffers not cleared.
// - Slot FSM: IDLE -aw hs-> COLLECT -last good beat-> READY -cmd taken-> ISSUED -oc bvalid/timeout-> RESP -B taken-> IDLE.
// - awready = slot[awid]==IDLE (registered state). awlen>=MAX_BEATS sets drop flag: beats accepted, discarded.
// - wready = slot[wid]==COLLECT. Beat n written to buffer[wid][n]; counter increments per beat.
// - wlast with count!=awlen, or count==awlen without wlast: slot -> RESP, BRESP=2'b10, no OC command. Drop flag: same on wlast.
// - Command arbiter: round-robin over READY slots; oc_write_command_ready asserts cycle after slot enters READY;
//   id/payload locked while ready & ~taken; pointer advances past granted id on taken.
// - ISSUED timer counts each cycle; at TIMEOUT_CYCLES -> RESP, BRESP=2'b11, timeout_err pulse.
//   oc_trans_bvalid in same cycle as expiry wins (oc bresp used, no pulse).
// - oc_trans_bvalid to slot not ISSUED: ignored, stray_resp pulse.
// - Response arbiter: round-robin over RESP slots, same locking rule. B taken and aw for same ID same cycle:
//   awready low that cycle, aw accepted next cycle.
// - Latency: last beat -> command valid 1 cycle; oc bvalid -> B valid 2 cycles.
// STRUCTURE
// - ocx_tlx_axi_pkg: slot state encoding, BRESP codes (OKAY/SLVERR/DECERR), timer width $clog2(TIMEOUT_CYCLES+1).
// - One sub-module ocx_tlx_axi_rr_lock: round-robin arbiter with grant lock, instanced for command and response.
// TESTING
// - aw id3 len1 addr 0x100, beats A,B wlast -> cmd id3 len1 data {B,A} next cycle; oc bresp 0 -> B id3 OKAY.
// - aw id1 len3, wlast on beat 2 -> no command; B id1 BRESP=2'b10; slot 1 accepts new aw after B taken.
// - TIMEOUT_CYCLES=8, cmd id5 taken, no oc response -> timeout_err on cycle 8, B id5 2'b11; late oc bvalid id5 -> stray_resp.
// - Slots 0,2,7 READY together, taken held low 3 cycles -> id stays 0; then grants 0,2,7 in order.
// - Reset asserted mid-burst on id4 -> all outputs 0 immediately; after release, aw id4 accepted, no stale data issued.
// - aw id6 awlen=8 (MAX_BEATS=4), 9 beats -> all beats accepted, B id6 SLVERR, no OC command.

Source files
------------

// File: rtl/ocx_tlx_axi_pkg.sv
// Shared types for the OpenCAPI AXI write tracker: slot states, AXI BRESP codes, timer sizing.
package ocx_tlx_axi_pkg;

    typedef enum logic [2:0] {
        SLOT_IDLE,
        SLOT_COLLECT,
        SLOT_READY,
        SLOT_ISSUED,
        SLOT_RESP
    } slot_state_e;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_e;

    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ocx_tlx_axi_rr_lock.sv
// Round-robin arbiter over 2**ID_WIDTH requesters; a grant stays locked until it is taken.
module ocx_tlx_axi_rr_lock #(
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [2**ID_WIDTH-1:0]   req_i,
    input  logic                     taken_i,
    output logic                     valid_o,
    output logic [ID_WIDTH-1:0]      id_o
);
    localparam int unsigned N = 2**ID_WIDTH;

    logic                lock_q;
    logic [ID_WIDTH-1:0] lock_id_q;
    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] idx;

    // Search starts at ptr_q; index wraps naturally because N is a power of two.
    always_comb begin
        valid_o = lock_q;
        id_o    = lock_q ? lock_id_q : '0;
        idx     = '0;
        if (!lock_q) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = ptr_q + ID_WIDTH'(k);
                if (!valid_o && req_i[idx]) begin
                    valid_o = 1'b1;
                    id_o    = idx;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            ptr_q     <= '0;
        end else if (valid_o) begin
            if (taken_i) begin
                lock_q <= 1'b0;
                ptr_q  <= id_o + ID_WIDTH'(1);
            end else begin
                lock_q    <= 1'b1;
                lock_id_q <= id_o;
            end
        end
    end

endmodule

// File: rtl/ocx_tlx_axi_wr_tracker.sv
// Per-ID AXI write tracker: gathers write beats per slot, issues one OpenCAPI command per slot,
// and returns B responses, retiring ISSUED slots that time out.
module ocx_tlx_axi_wr_tracker
    import ocx_tlx_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned MAX_BEATS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            s0_axi_aclk,
    input  logic                            s0_axi_aresetn,
    input  logic [ID_WIDTH-1:0]             axi_trans_awid,
    input  logic [ADDR_WIDTH-1:0]           axi_trans_awaddr,
    input  logic [7:0]                      axi_trans_awlen,
    input  logic                            axi_trans_awvalid,
    output logic                            axi_trans_awready,
    input  logic [ID_WIDTH-1:0]             axi_trans_wid,
    input  logic [DATA_WIDTH-1:0]           axi_trans_wdata,
    input  logic                            axi_trans_wlast,
    input  logic                            axi_trans_wvalid,
    output logic                            axi_trans_wready,
    output logic                            axi_write_response_ready,
    output logic [ID_WIDTH-1:0]             axi_write_response_ready_id,
    output logic [1:0]                      axi_write_response_ready_response,
    input  logic                            axi_write_response_taken,
    output logic                            oc_write_command_ready,
    output logic [ID_WIDTH-1:0]             oc_write_command_ready_id,
    output logic [ADDR_WIDTH-1:0]           oc_write_command_ready_address,
    output logic [7:0]                      oc_write_command_ready_length,
    output logic [MAX_BEATS*DATA_WIDTH-1:0] oc_write_command_ready_data,
    input  logic                            oc_write_command_taken,
    input  logic                            oc_trans_bvalid,
    input  logic [ID_WIDTH-1:0]             oc_trans_bid,
    input  logic [1:0]                      oc_trans_bresp,
    output logic                            timeout_err,
    output logic                            stray_resp
);
    localparam int unsigned NSLOT = 2**ID_WIDTH;
    localparam int unsigned BW    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int unsigned TW    = timer_width(TIMEOUT_CYCLES);

    slot_state_e           state_q [NSLOT];
    slot_state_e           state_d [NSLOT];
    logic [7:0]            cnt_q   [NSLOT];
    logic [7:0]            cnt_d   [NSLOT];
    logic [TW-1:0]         timer_q [NSLOT];
    logic [TW-1:0]         timer_d [NSLOT];
    bresp_e                bresp_q [NSLOT];
    bresp_e                bresp_d [NSLOT];
    logic [ADDR_WIDTH-1:0] addr_q  [NSLOT];
    logic [7:0]            len_q   [NSLOT];
    logic                  drop_q  [NSLOT];
    logic [DATA_WIDTH-1:0] buf_q   [NSLOT][MAX_BEATS];

    logic                run_q;
    logic                ocb_valid_q;
    logic [ID_WIDTH-1:0] ocb_id_q;
    logic [1:0]          ocb_resp_q;
    logic                timeout_q, timeout_d;
    logic                stray_q, stray_d;

    logic [NSLOT-1:0]    cmd_req, rsp_req;
    logic                cmd_valid, rsp_valid;
    logic [ID_WIDTH-1:0] cmd_id, rsp_id;
    logic                aw_hs, w_hs, cmd_hs, rsp_hs;

    // run_q keeps the AXI ready outputs low while reset is held.
    assign axi_trans_awready = run_q && (state_q[axi_trans_awid] == SLOT_IDLE);
    assign axi_trans_wready  = run_q && (state_q[axi_trans_wid] == SLOT_COLLECT);
    assign aw_hs  = axi_trans_awvalid && axi_trans_awready;
    assign w_hs   = axi_trans_wvalid && axi_trans_wready;
    assign cmd_hs = cmd_valid && oc_write_command_taken;
    assign rsp_hs = rsp_valid && axi_write_response_taken;

    always_comb begin
        for (int unsigned i = 0; i < NSLOT; i++) begin
            cmd_req[i] = (state_q[i] == SLOT_READY);
            rsp_req[i] = (state_q[i] == SLOT_RESP);
        end
    end

    ocx_tlx_axi_rr_lock #(.ID_WIDTH(ID_WIDTH)) u_cmd_arb (
        .clk_i   (s0_axi_aclk),
        .rst_ni  (s0_axi_aresetn),
        .req_i   (cmd_req),
        .taken_i (oc_write_command_taken),
        .valid_o (cmd_valid),
        .id_o    (cmd_id)
    );

    ocx_tlx_axi_rr_lock #(.ID_WIDTH(ID_WIDTH)) u_rsp_arb (
        .clk_i   (s0_axi_aclk),
        .rst_ni  (s0_axi_aresetn),
        .req_i   (rsp_req),
        .taken_i (axi_write_response_taken),
        .valid_o (rsp_valid),
        .id_o    (rsp_id)
    );

    always_comb begin
        timeout_d = 1'b0;
        stray_d   = ocb_valid_q && (state_q[ocb_id_q] != SLOT_ISSUED);
        for (int unsigned i = 0; i < NSLOT; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            timer_d[i] = timer_q[i];
            bresp_d[i] = bresp_q[i];
            case (state_q[i])
                SLOT_IDLE: begin
                    if (aw_hs && axi_trans_awid == ID_WIDTH'(i)) begin
                        state_d[i] = SLOT_COLLECT;
                        cnt_d[i]   = '0;
                    end
                end
                SLOT_COLLECT: begin
                    if (w_hs && axi_trans_wid == ID_WIDTH'(i)) begin
                        if (drop_q[i]) begin
                            if (axi_trans_wlast) begin
                                state_d[i] = SLOT_RESP;
                                bresp_d[i] = BRESP_SLVERR;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 8'd1;
                            end
                        end else if (axi_trans_wlast && cnt_q[i] == len_q[i]) begin
                            state_d[i] = SLOT_READY;
                        end else if (axi_trans_wlast || cnt_q[i] == len_q[i]) begin
                            state_d[i] = SLOT_RESP;
                            bresp_d[i] = BRESP_SLVERR;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                end
                SLOT_READY: begin
                    if (cmd_hs && cmd_id == ID_WIDTH'(i)) begin
                        state_d[i] = SLOT_ISSUED;
                        timer_d[i] = '0;
                    end
                end
                SLOT_ISSUED: begin
                    // An OpenCAPI response takes priority over a coincident expiry.
                    if (ocb_valid_q && ocb_id_q == ID_WIDTH'(i)) begin
                        state_d[i] = SLOT_RESP;
                        bresp_d[i] = bresp_e'(ocb_resp_q);
                    end else if (TIMEOUT_CYCLES != 0 && timer_q[i] == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d[i] = SLOT_RESP;
                        bresp_d[i] = BRESP_DECERR;
                        timeout_d  = 1'b1;
                    end else begin
                        timer_d[i] = timer_q[i] + TW'(1);
                    end
                end
                SLOT_RESP: begin
                    if (rsp_hs && rsp_id == ID_WIDTH'(i)) begin
                        state_d[i] = SLOT_IDLE;
                    end
                end
                default: state_d[i] = SLOT_IDLE;
            endcase
        end
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                state_q[i] <= SLOT_IDLE;
                cnt_q[i]   <= '0;
                timer_q[i] <= '0;
                bresp_q[i] <= BRESP_OKAY;
            end
            run_q       <= 1'b0;
            ocb_valid_q <= 1'b0;
            ocb_id_q    <= '0;
            ocb_resp_q  <= '0;
            timeout_q   <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                timer_q[i] <= timer_d[i];
                bresp_q[i] <= bresp_d[i];
            end
            run_q       <= 1'b1;
            ocb_valid_q <= oc_trans_bvalid;
            ocb_id_q    <= oc_trans_bid;
            ocb_resp_q  <= oc_trans_bresp;
            timeout_q   <= timeout_d;
            stray_q     <= stray_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge s0_axi_aclk) begin
        if (aw_hs) begin
            addr_q[axi_trans_awid] <= axi_trans_awaddr;
            len_q[axi_trans_awid]  <= axi_trans_awlen;
            drop_q[axi_trans_awid] <= (axi_trans_awlen >= 8'(MAX_BEATS));
        end
        if (w_hs && !drop_q[axi_trans_wid] && cnt_q[axi_trans_wid] < 8'(MAX_BEATS)) begin
            buf_q[axi_trans_wid][cnt_q[axi_trans_wid][BW-1:0]] <= axi_trans_wdata;
        end
    end

    always_comb begin
        oc_write_command_ready_data = '0;
        if (cmd_valid) begin
            for (int unsigned b = 0; b < MAX_BEATS; b++) begin
                oc_write_command_ready_data[b*DATA_WIDTH +: DATA_WIDTH] = buf_q[cmd_id][b];
            end
        end
    end

    assign oc_write_command_ready            = cmd_valid;
    assign oc_write_command_ready_id         = cmd_id;
    assign oc_write_command_ready_address    = cmd_valid ? addr_q[cmd_id] : '0;
    assign oc_write_command_ready_length     = cmd_valid ? len_q[cmd_id] : '0;
    assign axi_write_response_ready          = rsp_valid;
    assign axi_write_response_ready_id       = rsp_id;
    assign axi_write_response_ready_response = rsp_valid ? bresp_q[rsp_id] : 2'b00;
    assign timeout_err                       = timeout_q;
    assign stray_resp                        = stray_q;

endmodule

// File: tb/tb_ocx_tlx_axi_wr_tracker.sv
// Scoreboard bench for ocx_tlx_axi_wr_tracker: directed scenarios followed by randomized writes.
module tb_ocx_tlx_axi_wr_tracker;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] awid = '0;  logic [63:0] awaddr = '0; logic [7:0] awlen = '0; logic awvalid = 1'b0; logic awready;
    logic [3:0] wid = '0;   logic [63:0] wdata = '0;  logic wlast = 1'b0;     logic wvalid = 1'b0;  logic wready;
    logic b_valid; logic [3:0] b_id; logic [1:0] b_resp; logic b_taken = 1'b0;
    logic cmd_valid; logic [3:0] cmd_id; logic [63:0] cmd_addr; logic [7:0] cmd_len; logic [255:0] cmd_data;
    logic cmd_taken = 1'b0;
    logic oc_bvalid = 1'b0; logic [3:0] oc_bid = '0; logic [1:0] oc_bresp = '0;
    logic timeout_err, stray_resp;

    ocx_tlx_axi_wr_tracker #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4), .MAX_BEATS(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
        .axi_trans_awid(awid), .axi_trans_awaddr(awaddr), .axi_trans_awlen(awlen),
        .axi_trans_awvalid(awvalid), .axi_trans_awready(awready),
        .axi_trans_wid(wid), .axi_trans_wdata(wdata), .axi_trans_wlast(wlast),
        .axi_trans_wvalid(wvalid), .axi_trans_wready(wready),
        .axi_write_response_ready(b_valid), .axi_write_response_ready_id(b_id),
        .axi_write_response_ready_response(b_resp), .axi_write_response_taken(b_taken),
        .oc_write_command_ready(cmd_valid), .oc_write_command_ready_id(cmd_id),
        .oc_write_command_ready_address(cmd_addr), .oc_write_command_ready_length(cmd_len),
        .oc_write_command_ready_data(cmd_data), .oc_write_command_taken(cmd_taken),
        .oc_trans_bvalid(oc_bvalid), .oc_trans_bid(oc_bid), .oc_trans_bresp(oc_bresp),
        .timeout_err(timeout_err), .stray_resp(stray_resp)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] addr; logic [7:0] len; logic [255:0] data; } cmd_t;
    typedef struct { int id; longint due; } pend_t;

    int total = 0, bad = 0;
    cmd_t cmdq[16][$];
    logic [1:0] bq[16][$];
    pend_t pending[$];
    bit [15:0] busy = '0;
    bit noresp[16];
    longint take_cyc[16];
    int cmd_mode = 1, b_mode = 1, stray_req = -1, to_id = 5;
    bit rand_bresp = 1'b1, log_grants = 1'b0;
    int grant_log[$];
    int exp_timeouts = 0, got_timeouts = 0, exp_strays = 0, got_strays = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Command sink: expected command per ID is checked on every accepted command.
    initial begin
        cmd_t e;
        logic [255:0] m;
        int id;
        forever begin
            @(posedge clk); #1;
            cmd_taken = (cmd_mode == 2) || (cmd_mode == 1 && ($urandom % 2 == 1));
            @(negedge clk);
            if (rst_n && cmd_valid && cmd_taken) begin
                id = int'(cmd_id);
                if (log_grants) grant_log.push_back(id);
                if (cmdq[id].size() == 0) begin
                    check("cmd_expected_present", 0, 1);
                end else begin
                    e = cmdq[id].pop_front();
                    check("cmd_addr", cmd_addr, e.addr);
                    check("cmd_len", cmd_len, e.len);
                    m = '0;
                    for (int b = 0; b <= int'(e.len) && b < 4; b++) m[b*64 +: 64] = '1;
                    check("cmd_data", cmd_data & m, e.data & m);
                    take_cyc[id] = cyc + 1;
                    pending.push_back('{id: id, due: cyc + 1 + longint'($urandom_range(0, 3))});
                end
            end
        end
    end

    // OpenCAPI responder: answers issued commands after a short delay and predicts the B code.
    initial begin
        pend_t p;
        logic [1:0] r;
        forever begin
            @(posedge clk); #1;
            oc_bvalid = 1'b0; oc_bid = '0; oc_bresp = '0;
            if (stray_req >= 0) begin
                oc_bvalid = 1'b1; oc_bid = 4'(stray_req); oc_bresp = 2'b00;
                stray_req = -1;
            end else if (pending.size() > 0 && pending[0].due <= cyc) begin
                p = pending.pop_front();
                if (noresp[p.id]) begin
                    bq[p.id].push_back(2'b11);
                    exp_timeouts++;
                end else begin
                    r = (rand_bresp && ($urandom % 2 == 1)) ? 2'b10 : 2'b00;
                    oc_bvalid = 1'b1; oc_bid = 4'(p.id); oc_bresp = r;
                    bq[p.id].push_back(r);
                end
            end
        end
    end

    // B sink: pops the per-ID expected response when a B handshake occurs.
    initial begin
        int id;
        forever begin
            @(posedge clk); #1;
            b_taken = (b_mode == 2) || (b_mode == 1 && ($urandom % 2 == 1));
            @(negedge clk);
            if (rst_n && b_valid && b_taken) begin
                id = int'(b_id);
                if (bq[id].size() == 0) check("b_expected_present", 0, 1);
                else check("bresp", b_resp, bq[id].pop_front());
                busy[id] = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (timeout_err) begin
                got_timeouts++;
                check("timeout_latency", cyc - take_cyc[to_id], TMO);
            end
            if (stray_resp) got_strays++;
        end
    end

    task automatic send_aw(input int id, input logic [63:0] addr, input logic [7:0] len);
        awid = 4'(id); awaddr = addr; awlen = len; awvalid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (awready) break;
        end
        check("awready_seen", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input int id, input logic [63:0] d, input logic last);
        wid = 4'(id); wdata = d; wlast = last; wvalid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (wready) break;
        end
        check("wready_seen", wready, 1'b1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    // kind: 0 well-formed, 1 early wlast after nb_early beats, 2 no wlast; awlen>=4 is a dropped burst.
    task automatic write_txn(input int id, input logic [63:0] addr, input logic [7:0] len,
                             input int kind, input int nb_early, input logic [255:0] dat);
        int nb;
        bit lastflag;
        cmd_t e;
        logic [63:0] bd;
        busy[id] = 1'b1;
        if (len >= 8'd4) begin
            nb = int'(len) + 1; lastflag = 1'b1; bq[id].push_back(2'b10);
        end else if (kind == 1) begin
            nb = nb_early; lastflag = 1'b1; bq[id].push_back(2'b10);
        end else if (kind == 2) begin
            nb = int'(len) + 1; lastflag = 1'b0; bq[id].push_back(2'b10);
        end else begin
            nb = int'(len) + 1; lastflag = 1'b1;
            e.addr = addr; e.len = len; e.data = dat;
            cmdq[id].push_back(e);
        end
        send_aw(id, addr, len);
        for (int b = 0; b < nb; b++) begin
            if (b < 4) bd = dat[b*64 +: 64];
            else bd = {$urandom, $urandom};
            send_w(id, bd, lastflag && (b == nb - 1));
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (busy == '0 && pending.size() == 0 && stray_req < 0) break;
        end
        check("drain_busy", {busy, 16'(pending.size())}, 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] d;
        int id, len, kind, r;
        #23;
        check("reset_ctrl", {awready, wready, b_valid, b_id, b_resp, cmd_valid, cmd_id, cmd_addr,
                             cmd_len, timeout_err, stray_resp}, '0);
        check("reset_cmd_data", cmd_data, '0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // id3, two beats: command one cycle after the last beat, beat0 in the low word.
        cmd_mode = 0; rand_bresp = 1'b0;
        d = '0; d[63:0] = 64'hAAAA_AAAA_0000_000A; d[127:64] = 64'hBBBB_BBBB_0000_000B;
        write_txn(3, 64'h100, 8'd1, 0, 0, d);
        @(negedge clk);
        check("cmd_next_cycle", {cmd_valid, cmd_id, cmd_len}, {1'b1, 4'd3, 8'd1});
        check("cmd_payload_ab", cmd_data[127:0], d[127:0]);
        @(posedge clk); #1; cmd_mode = 1;
        wait_idle();

        // id1 awlen=3 with wlast on the third beat, then a fresh write on id1.
        write_txn(1, 64'h200, 8'd3, 1, 3, rnd256());
        wait_idle();
        write_txn(1, 64'h240, 8'd0, 0, 0, rnd256());
        wait_idle();

        // id5 never answered: DECERR after TMO cycles, then a late response is stray.
        noresp[5] = 1'b1; to_id = 5;
        write_txn(5, 64'h500, 8'd0, 0, 0, rnd256());
        wait_idle();
        check("timeout_pulses", got_timeouts, 1);
        noresp[5] = 1'b0;
        stray_req = 5; exp_strays = 1;
        repeat (5) @(posedge clk); #1;
        check("stray_pulses", got_strays, 1);

        // Slots 0,2,7 READY together with taken low: grant held on 0, then 0,2,7.
        cmd_mode = 0;
        write_txn(0, 64'h1000, 8'd0, 0, 0, rnd256());
        write_txn(2, 64'h2000, 8'd0, 0, 0, rnd256());
        write_txn(7, 64'h7000, 8'd2, 0, 0, rnd256());
        repeat (3) begin
            @(negedge clk);
            check("grant_hold", {cmd_valid, cmd_id}, {1'b1, 4'd0});
        end
        @(posedge clk); #1;
        log_grants = 1'b1; cmd_mode = 2;
        wait_idle();
        log_grants = 1'b0; cmd_mode = 1;
        check("grant_count", grant_log.size(), 3);
        if (grant_log.size() == 3)
            check("grant_order", {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0]}, {4'd0, 4'd2, 4'd7});

        // Reset in the middle of an id4 burst.
        busy[4] = 1'b1;
        send_aw(4, 64'h4000, 8'd3);
        send_w(4, 64'hDEAD_0000_0000_0000, 1'b0);
        send_w(4, 64'hDEAD_0000_0000_0001, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midreset_ctrl", {awready, wready, b_valid, b_id, b_resp, cmd_valid, cmd_id, cmd_addr,
                                cmd_len, timeout_err, stray_resp}, '0);
        check("midreset_cmd_data", cmd_data, '0);
        busy[4] = 1'b0;
        @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        write_txn(4, 64'h4400, 8'd0, 0, 0, rnd256());
        wait_idle();

        // awlen=8 exceeds buffer depth: 9 beats accepted, SLVERR, no command.
        write_txn(6, 64'h6000, 8'd8, 0, 0, rnd256());
        wait_idle();

        // Randomized traffic.
        rand_bresp = 1'b1;
        for (int t = 0; t < 60; t++) begin
            id = 0;
            for (int k = 0; k < 1000; k++) begin
                id = int'($urandom % 16);
                if (!busy[id]) break;
                @(posedge clk); #1;
            end
            len = int'($urandom_range(0, 5));
            r = int'($urandom % 6);
            kind = (len >= 1 && r == 0) ? 1 : (r == 1 ? 2 : 0);
            write_txn(id, {$urandom, $urandom}, 8'(len), kind,
                      (len >= 1) ? int'($urandom_range(1, len)) : 1, rnd256());
        end
        wait_idle();

        check("timeout_total", got_timeouts, exp_timeouts);
        check("stray_total", got_strays, exp_strays);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1);
    end

endmodule
